// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined Hsiao SEC-DED decoder with valid/ready flow control,
// saturating error counters and a sticky capture of the first uncorrectable address.
module secded_dec_pipe #(
    parameter int DATA_W = 64,
    parameter int CHK_W  = 8,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16,
    localparam int POS_W = $clog2(DATA_W + CHK_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CHK_W-1:0]  in_chk,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              corr_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CHK_W-1:0]  out_syn,
    output logic              out_sgl,
    output logic              out_unc,
    output logic [POS_W-1:0]  out_pos,
    input  logic              clr,
    output logic [CNT_W-1:0]  sgl_cnt,
    output logic [CNT_W-1:0]  unc_cnt,
    output logic              unc_vld,
    output logic [ADDR_W-1:0] unc_addr
);

    // Data columns: odd-weight values of weight >= 3, lowest weight first, ascending within a weight.
    function automatic logic [DATA_W-1:0][CHK_W-1:0] gen_cols();
        logic [DATA_W-1:0][CHK_W-1:0] cols;
        logic [CHK_W-1:0]             v;
        int                           n;
        int                           ones;
        cols = '0;
        n    = 0;
        for (int w = 3; w <= CHK_W; w += 2) begin
            for (int i = 0; i < (1 << CHK_W); i++) begin
                v    = CHK_W'(i);
                ones = 0;
                for (int b = 0; b < CHK_W; b++) begin
                    ones += int'(v[b]);
                end
                if (ones == w && n < DATA_W) begin
                    cols[n] = v;
                    n++;
                end
            end
        end
        return cols;
    endfunction

    localparam logic [DATA_W-1:0][CHK_W-1:0] COLS = gen_cols();

    logic              adv1;
    logic              adv2;
    logic              xfer;

    logic [CHK_W-1:0]  syn_c;

    logic              v1_q;
    logic [DATA_W-1:0] data1_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [CHK_W-1:0]  syn1_q;
    logic              corr1_q;

    logic [DATA_W-1:0] flip_c;
    logic              hit_c;
    logic              odd_c;
    logic              sgl_d;
    logic              unc_d;
    logic [POS_W-1:0]  pos_d;
    logic [DATA_W-1:0] data2_d;

    logic              v2_q;
    logic [DATA_W-1:0] data2_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [CHK_W-1:0]  syn2_q;
    logic              sgl2_q;
    logic              unc2_q;
    logic [POS_W-1:0]  pos2_q;

    logic [CNT_W-1:0]  sgl_cnt_q, sgl_cnt_d;
    logic [CNT_W-1:0]  unc_cnt_q, unc_cnt_d;
    logic              unc_vld_q, unc_vld_d;
    logic [ADDR_W-1:0] unc_addr_q, unc_addr_d;

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;
    assign xfer     = v2_q && out_ready;

    always_comb begin
        syn_c = in_chk;
        for (int j = 0; j < DATA_W; j++) begin
            if (in_data[j]) begin
                syn_c = syn_c ^ COLS[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            data1_q <= '0;
            addr1_q <= '0;
            syn1_q  <= '0;
            corr1_q <= 1'b0;
        end else if (adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                data1_q <= in_data;
                addr1_q <= in_addr;
                syn1_q  <= syn_c;
                corr1_q <= corr_en;
            end
        end
    end

    always_comb begin
        flip_c = '0;
        hit_c  = 1'b0;
        pos_d  = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (syn1_q == COLS[j]) begin
                flip_c[j] = 1'b1;
                hit_c     = 1'b1;
                pos_d     = POS_W'(j);
            end
        end
        for (int k = 0; k < CHK_W; k++) begin
            if (syn1_q == (CHK_W'(1) << k)) begin
                hit_c = 1'b1;
                pos_d = POS_W'(DATA_W + k);
            end
        end
        // Even-weight syndromes can never be a single flip, whatever they match.
        odd_c = ^syn1_q;
        sgl_d = odd_c && hit_c;
        unc_d = (syn1_q != '0) && !sgl_d;
        if (!sgl_d) begin
            pos_d = '0;
        end
        data2_d = (corr1_q && sgl_d) ? (data1_q ^ flip_c) : data1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            data2_q <= '0;
            addr2_q <= '0;
            syn2_q  <= '0;
            sgl2_q  <= 1'b0;
            unc2_q  <= 1'b0;
            pos2_q  <= '0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                data2_q <= data2_d;
                addr2_q <= addr1_q;
                syn2_q  <= syn1_q;
                sgl2_q  <= sgl_d;
                unc2_q  <= unc_d;
                pos2_q  <= pos_d;
            end
        end
    end

    // clr wins over a same-cycle event so software sees a clean zero after clearing.
    always_comb begin
        sgl_cnt_d  = sgl_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        unc_vld_d  = unc_vld_q;
        unc_addr_d = unc_addr_q;
        if (clr) begin
            sgl_cnt_d  = '0;
            unc_cnt_d  = '0;
            unc_vld_d  = 1'b0;
            unc_addr_d = '0;
        end else if (xfer) begin
            if (sgl2_q && sgl_cnt_q != {CNT_W{1'b1}}) begin
                sgl_cnt_d = sgl_cnt_q + CNT_W'(1);
            end
            if (unc2_q && unc_cnt_q != {CNT_W{1'b1}}) begin
                unc_cnt_d = unc_cnt_q + CNT_W'(1);
            end
            if (unc2_q && !unc_vld_q) begin
                unc_vld_d  = 1'b1;
                unc_addr_d = addr2_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgl_cnt_q  <= '0;
            unc_cnt_q  <= '0;
            unc_vld_q  <= 1'b0;
            unc_addr_q <= '0;
        end else begin
            sgl_cnt_q  <= sgl_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
            unc_vld_q  <= unc_vld_d;
            unc_addr_q <= unc_addr_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = data2_q;
    assign out_addr  = addr2_q;
    assign out_syn   = syn2_q;
    assign out_sgl   = sgl2_q;
    assign out_unc   = unc2_q;
    assign out_pos   = pos2_q;
    assign sgl_cnt   = sgl_cnt_q;
    assign unc_cnt   = unc_cnt_q;
    assign unc_vld   = unc_vld_q;
    assign unc_addr  = unc_addr_q;

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Bench for secded_dec_pipe: directed vector table, hand-written flow-control/counter
// sequences, and a random stream scored against a column-lookup model.
module tb_secded_dec_pipe;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int AW = 32;
    localparam int PW = 7;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] syn;
        logic          sgl;
        logic          unc;
        logic [PW-1:0] pos;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic [AW-1:0] a;
        logic          ce;
        logic [DW-1:0] xd;
        logic [CW-1:0] xs;
        logic          xsgl;
        logic          xunc;
        int            xpos;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_chk;
    logic [AW-1:0] in_addr;
    logic          corr_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [CW-1:0] out_syn;
    logic          out_sgl;
    logic          out_unc;
    logic [PW-1:0] out_pos;
    logic          clr;
    logic [15:0]   sgl_cnt;
    logic [15:0]   unc_cnt;
    logic          unc_vld;
    logic [AW-1:0] unc_addr;

    logic          s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [AW-1:0] s_out_addr;
    logic [CW-1:0] s_out_syn;
    logic          s_out_sgl;
    logic          s_out_unc;
    logic [PW-1:0] s_out_pos;
    logic [1:0]    s_sgl_cnt;
    logic [1:0]    s_unc_cnt;
    logic          s_unc_vld;
    logic [AW-1:0] s_unc_addr;

    secded_dec_pipe #(.DATA_W(DW), .CHK_W(CW), .ADDR_W(AW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_chk(in_chk), .in_addr(in_addr), .corr_en(corr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_syn(out_syn), .out_sgl(out_sgl), .out_unc(out_unc),
        .out_pos(out_pos), .clr(clr), .sgl_cnt(sgl_cnt), .unc_cnt(unc_cnt),
        .unc_vld(unc_vld), .unc_addr(unc_addr)
    );

    // Narrow-counter instance sharing all inputs, used for saturation.
    secded_dec_pipe #(.DATA_W(DW), .CHK_W(CW), .ADDR_W(AW), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_chk(in_chk), .in_addr(in_addr), .corr_en(corr_en),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_addr(s_out_addr), .out_syn(s_out_syn), .out_sgl(s_out_sgl), .out_unc(s_out_unc),
        .out_pos(s_out_pos), .clr(clr), .sgl_cnt(s_sgl_cnt), .unc_cnt(s_unc_cnt),
        .unc_vld(s_unc_vld), .unc_addr(s_unc_addr)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_in = 0;
    int            n_out = 0;
    int            cyc = 0;
    logic [CW-1:0] mcol [DW+CW];
    exp_t          q[$];
    int            m_sgl, m_unc, ms_sgl, ms_unc;
    logic          m_vld;
    logic [AW-1:0] m_addr;
    logic          hold;
    exp_t          h;
    logic          rnd_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic build_cols();
        int n;
        logic [CW-1:0] v;
        n = 0;
        for (int w = 3; w <= CW; w += 2) begin
            for (int i = 0; i < 256; i++) begin
                v = CW'(i);
                if ($countones(v) == w && n < DW) begin
                    mcol[n] = v;
                    n++;
                end
            end
        end
        for (int k = 0; k < CW; k++) mcol[DW+k] = CW'(1) << k;
    endtask

    function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
        logic [CW-1:0] x;
        x = '0;
        for (int j = 0; j < DW; j++) if (d[j]) x ^= mcol[j];
        return x;
    endfunction

    // Reference: syndrome by XOR, then look it up among all 72 codeword columns.
    function automatic exp_t model(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                   input logic [AW-1:0] a, input logic ce);
        exp_t e;
        int   idx;
        e.syn  = c ^ enc(d);
        e.data = d;
        e.addr = a;
        e.sgl  = 1'b0;
        e.unc  = 1'b0;
        e.pos  = '0;
        if (e.syn != '0) begin
            idx = -1;
            for (int i = DW + CW - 1; i >= 0; i--) if (mcol[i] == e.syn) idx = i;
            if (idx >= 0) begin
                e.sgl = 1'b1;
                e.pos = PW'(idx);
                if (ce && idx < DW) e.data[idx] = ~e.data[idx];
            end else begin
                e.unc = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic vec_t mkv(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic [AW-1:0] a, input logic ce,
                                 input logic [DW-1:0] xd, input logic [CW-1:0] xs,
                                 input logic xsgl, input logic xunc, input int xpos);
        vec_t v;
        v.d = d; v.c = c; v.a = a; v.ce = ce;
        v.xd = xd; v.xs = xs; v.xsgl = xsgl; v.xunc = xunc; v.xpos = xpos;
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic xs, xu, xf;
        if (!rst_n) begin
            q.delete();
            m_sgl = 0; m_unc = 0; ms_sgl = 0; ms_unc = 0;
            m_vld = 1'b0; m_addr = '0; hold = 1'b0;
        end else begin
            check("sgl_cnt", sgl_cnt, m_sgl);
            check("unc_cnt", unc_cnt, m_unc);
            check("unc_vld", unc_vld, m_vld);
            check("unc_addr", unc_addr, m_addr);
            check("s_sgl_cnt", s_sgl_cnt, ms_sgl);
            check("s_unc_cnt", s_unc_cnt, ms_unc);
            check("s_unc_vld", s_unc_vld, m_vld);
            check("s_unc_addr", s_unc_addr, m_addr);
            check("s_out_valid", s_out_valid, out_valid);
            check("s_in_ready", s_in_ready, in_ready);
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, h.data);
                check("hold_addr", out_addr, h.addr);
                check("hold_flags", {out_syn, out_sgl, out_unc, out_pos}, {h.syn, h.sgl, h.unc, h.pos});
            end
            hold   = out_valid && !out_ready;
            h.data = out_data; h.addr = out_addr; h.syn = out_syn;
            h.sgl  = out_sgl;  h.unc = out_unc;   h.pos = out_pos;
            xf = 1'b0; xs = 1'b0; xu = 1'b0;
            if (out_valid && out_ready) begin
                xf = 1'b1;
                n_out++;
                if (q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_beat: got addr %h expected none", out_addr);
                end else begin
                    e = q.pop_front();
                    xs = e.sgl; xu = e.unc;
                    check("sb_data", out_data, e.data);
                    check("sb_addr", out_addr, e.addr);
                    check("sb_syn", out_syn, e.syn);
                    check("sb_sgl", out_sgl, e.sgl);
                    check("sb_unc", out_unc, e.unc);
                    check("sb_pos", out_pos, e.pos);
                    check("sb_s_out", {s_out_data, s_out_addr, s_out_syn, s_out_sgl, s_out_unc, s_out_pos} == {e.data, e.addr, e.syn, e.sgl, e.unc, e.pos}, 1);
                end
            end
            if (clr) begin
                m_sgl = 0; m_unc = 0; ms_sgl = 0; ms_unc = 0;
                m_vld = 1'b0; m_addr = '0;
            end else if (xf) begin
                if (xs && m_sgl < 65535) m_sgl++;
                if (xu && m_unc < 65535) m_unc++;
                if (xs && ms_sgl < 3) ms_sgl++;
                if (xu && ms_unc < 3) ms_unc++;
                if (xu && !m_vld) begin m_vld = 1'b1; m_addr = e.addr; end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_data, in_chk, in_addr, corr_en));
                n_in++;
            end
        end
    end

    // Leaves in_valid asserted; the caller sends the next beat or drops in_valid.
    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic [AW-1:0] a, input logic ce);
        int t;
        t = 0;
        in_valid = 1'b1; in_data = d; in_chk = c; in_addr = a; corr_en = ce;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t          tbl[$];
        int            c0, lat, bin, bout, bsgl, nf, p;
        logic [71:0]   cw, msk;
        logic [DW-1:0] d;

        build_cols();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_chk = '0; in_addr = '0;
        corr_en = 1'b1; out_ready = 1'b1; clr = 1'b0; rnd_done = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sgl_cnt", sgl_cnt, 0);
        check("rst_unc_cnt", unc_cnt, 0);
        check("rst_unc_vld", unc_vld, 0);
        check("rst_unc_addr", unc_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        c0 = cyc;
        for (int i = 0; i < 8; i++) send('0, '0, AW'(i), 1'b1);
        in_valid = 1'b0;
        check("clean_throughput", cyc - c0, 8);
        drain();
        check("clean_sgl_cnt", sgl_cnt, 0);
        check("clean_unc_cnt", unc_cnt, 0);

        tbl.push_back(mkv(64'h0, 8'h00, 32'h10, 1, 64'h0, 8'h00, 0, 0, 0));
        tbl.push_back(mkv(64'h1, 8'h00, 32'h11, 1, 64'h0, 8'h07, 1, 0, 0));
        tbl.push_back(mkv(64'h1, 8'h00, 32'h12, 0, 64'h1, 8'h07, 1, 0, 0));
        tbl.push_back(mkv(64'h0, 8'h08, 32'h13, 1, 64'h0, 8'h08, 1, 0, 67));
        tbl.push_back(mkv(64'h3, 8'h00, 32'hA5, 1, 64'h3, 8'h0C, 0, 1, 0));
        tbl.push_back(mkv(64'h3, 8'h00, 32'h5A, 1, 64'h3, 8'h0C, 0, 1, 0));
        tbl.push_back(mkv(64'h10, 8'h00, 32'h14, 1, 64'h0, 8'h13, 1, 0, 4));
        tbl.push_back(mkv(64'h0100_0000_0000_0000, 8'h00, 32'h15, 1, 64'h0, 8'h1F, 1, 0, 56));
        tbl.push_back(mkv(64'h8000_0000_0000_0000, 8'h00, 32'h16, 0, 64'h8000_0000_0000_0000, 8'h57, 1, 0, 63));
        tbl.push_back(mkv(64'h0, 8'h57, 32'h17, 1, 64'h8000_0000_0000_0000, 8'h57, 1, 0, 63));
        tbl.push_back(mkv(64'h0, 8'h80, 32'h18, 1, 64'h0, 8'h80, 1, 0, 71));
        tbl.push_back(mkv(64'h0, 8'h03, 32'h19, 1, 64'h0, 8'h03, 0, 1, 0));
        tbl.push_back(mkv(64'h0, 8'h7F, 32'h1A, 1, 64'h0, 8'h7F, 0, 1, 0));
        tbl.push_back(mkv(64'h0, 8'hFF, 32'h1B, 1, 64'h0, 8'hFF, 0, 1, 0));
        tbl.push_back(mkv(64'h5, 8'h0A, 32'h1C, 1, 64'h5, 8'h00, 0, 0, 0));

        foreach (tbl[i]) begin
            send(tbl[i].d, tbl[i].c, tbl[i].a, tbl[i].ce);
            in_valid = 1'b0;
            lat = 0;
            while (lat < 10) begin
                @(negedge clk);
                lat++;
                if (out_valid) break;
            end
            check("tbl_latency", lat, 2);
            check("tbl_data", out_data, tbl[i].xd);
            check("tbl_syn", out_syn, tbl[i].xs);
            check("tbl_sgl", out_sgl, tbl[i].xsgl);
            check("tbl_unc", out_unc, tbl[i].xunc);
            check("tbl_pos", out_pos, tbl[i].xpos);
            check("tbl_addr", out_addr, tbl[i].a);
            @(posedge clk);
            #1;
        end
        drain();
        check("sticky_vld", unc_vld, 1);
        check("sticky_addr", unc_addr, 32'hA5);

        // Backpressure: two beats fill the pipe, then in_ready must drop.
        out_ready = 1'b0;
        bin = n_in; bout = n_out; bsgl = m_sgl;
        fork
            begin
                for (int i = 0; i < 4; i++) send(64'h1 << (i + 1), '0, 32'h100 + AW'(i), 1'b1);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_accepted", n_in - bin, 2);
                check("bp_in_ready", in_ready, 0);
                check("bp_no_out", n_out - bout, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", n_out - bout, 4);
        check("bp_sgl_cnt", sgl_cnt, bsgl + 4);

        // Saturation on the 2-bit instance, then clr racing an error transfer.
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        for (int i = 0; i < 5; i++) send(64'h1 << i, '0, 32'h200 + AW'(i), 1'b1);
        in_valid = 1'b0;
        drain();
        check("sat_s_sgl_cnt", s_sgl_cnt, 3);
        check("sat_sgl_cnt", sgl_cnt, 5);
        send(64'h20, '0, 32'h300, 1'b1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("clr_evt_valid", out_valid, 1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_evt_sgl_cnt", sgl_cnt, 0);
        check("clr_evt_s_sgl_cnt", s_sgl_cnt, 0);
        check("clr_evt_delivered", q.size(), 0);

        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    d  = {$urandom(), $urandom()};
                    cw = {enc(d), d};
                    nf = $urandom_range(0, 9);
                    nf = (nf < 4) ? 0 : (nf < 7) ? 1 : (nf < 9) ? 2 : 3;
                    msk = '0;
                    for (int f = 0; f < nf; f++) begin
                        do p = $urandom_range(0, 71); while (msk[p]);
                        msk[p] = 1'b1;
                    end
                    cw = cw ^ msk;
                    send(cw[DW-1:0], cw[71:DW], $urandom(), 1'($urandom_range(0, 1)));
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    clr = ($urandom_range(0, 63) == 0);
                end
                clr = 1'b0;
            end
        join
        drain();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(64'h1, '0, 32'h400, 1'b1);
        send(64'h3, '0, 32'h401, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sgl_cnt", sgl_cnt, 0);
        check("mid_rst_unc_vld", unc_vld, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_no_stale", out_valid, 0);
        send(64'h4, '0, 32'h500, 1'b1);
        in_valid = 1'b0;
        drain();
        check("post_rst_sgl_cnt", sgl_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
